alu_cmd_responder: RTL and testbench
====================================

// Module: alu_cmd_responder
// PURPOSE
//   Responder end of the ALU operation interface. Accepts {op,a,b,tag} commands from an external
//   initiator over a valid/ready request channel and executes them on an internal 6-bit ALU.
//   Returns {result,tag,flags} over a valid/ready response channel, with a small response buffer.
//   Sits between a command-issuing FSM/host and the ALU datapath.
// PARAMETERS
//   WIDTH       6  operand/result width in bits
//   TAG_W       2  width of the opaque request tag, echoed in the response
//   RESP_DEPTH  2  response FIFO depth (power of 2, >=2)
// PORTS
//   clk           in   1        rising-edge clock
//   reset         in   1        asynchronous, active-high reset
//   req_valid     in   1        request present
//   req_ready     out  1        responder accepts request this cycle
//   req_op        in   3        000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 SHL A by 1, 111 MUL
//   req_a, req_b  in   WIDTH    operands (two's complement)
//   req_tag       in   TAG_W    echoed tag
//   resp_valid    out  1        response FIFO non-empty
//   resp_ready    in   1        consumer pops head this cycle
//   result        out  WIDTH    head result
//   resp_tag      out  TAG_W    head tag
//   gt_zero_flag  out  1        signed result > 0 (= !SF & !ZF)
//   SF, CF, ZF    out  1        sign (result MSB), carry/borrow/shift-out/overflow, zero flag
//   err           out  1        head op was illegal
//   busy          out  1        FSM not in IDLE
// BEHAVIOUR
//   - Reset: FSM->IDLE, FIFO emptied, all outputs 0; req_ready 0 while reset asserted.
//   - Reset mid-operation abandons the in-flight op and all buffered responses; nothing is emitted.
//   - FSM states: IDLE, EXEC, MUL, PUSH.
//   - IDLE: req_ready = (fifo not full). On req_valid&req_ready, latch op/a/b/tag.
//     Next state: MUL if op==111 and ALU_MULT_EN is defined, else EXEC.
//   - EXEC: compute result and flags in one cycle -> PUSH.
//   - MUL: shift-add over exactly WIDTH cycles into a 2*WIDTH-bit product (unsigned) -> PUSH.
//   - PUSH: write the entry to the FIFO -> IDLE. Only one op is in flight at a time.
//     Acceptance is gated on not-full, so PUSH never meets a full FIFO.
//   - Latency (accept edge N -> resp_valid high): non-MUL N+3; MUL N+WIDTH+2.
//     Throughput is one request per 3 cycles.
//   - Arithmetic and flags:
//     - ADD: CF = carry out of the WIDTH+1-bit sum.
//     - SUB: a-b; CF = borrow (a<b unsigned).
//     - Logic ops and NOT: CF = 0.
//     - SHL: CF = a[MSB].
//     - MUL: result = product[WIDTH-1:0]; CF = |product[2W-1:W].
//     - ZF = (result==0); SF = result[WIDTH-1].
//   - FIFO: push and pop in the same cycle leave count unchanged. Pop when empty is ignored.
//     Response outputs show the head entry (0 when empty). Order is preserved.
//   - req_valid held while req_ready=0 is legal. Request inputs are ignored outside the IDLE
//     accept cycle.
// CONFIGURATION
//   ALU_MULT_EN defined:   op 111 = iterative multiply via MUL state, err=0.
//   ALU_MULT_EN undefined: op 111 takes the EXEC path with result 0, ZF=1, CF=SF=gt=0, err=1.
//                          The MUL state and multiplier logic are not built.
// STRUCTURE
//   Package alu_resp_pkg: opcode localparams (OP_ADD..OP_MUL), state encoding, flag bit indices.
//   Sub-module alu_resp_fifo: synchronous FIFO of {err,flags[3:0],tag,result}.
//   Ports: push, pop, full, empty, dout; reset clears it.
//   FSM, ALU and multiplier live in this module.
// TESTING (WIDTH=6, resp_ready=1 unless stated)
//   - ADD a=30 b=40 tag=1 -> result=6, CF=1, ZF=0, SF=0, gt=1, resp_tag=1, resp_valid at N+3.
//   - SUB 5-5 -> result=0, ZF=1, CF=0, gt=0; SUB 3-5 -> result=6'b111110, SF=1, CF=1, gt=0.
//   - MUL (ALU_MULT_EN):
//     - 7*9 -> result=63 (6'b111111), SF=1, CF=0, latency 8.
//     - 8*9 -> result=8, CF=1.
//     - Without the macro, op 111 -> result=0, err=1, ZF=1.
//   - Backpressure: resp_ready=0, issue 3 ADDs.
//     - Two are accepted and req_ready stays 0.
//     - After one pop the third is accepted.
//     - Responses arrive in tag order 0,1,2.
//   - Reset asserted during MUL cycle 3 with 1 entry buffered.
//     - All outputs go 0 immediately; resp_valid stays 0 after release.
//     - The next ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_resp_pkg.sv
// Shared constants for the ALU command responder: opcodes, FSM encoding, flag bit positions.
package alu_resp_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StMul  = 2'd2;
  localparam logic [1:0] StPush = 2'd3;

  // Bit positions inside the 4-bit flag field stored in each response entry.
  localparam int unsigned FLAG_ZF   = 0;
  localparam int unsigned FLAG_CF   = 1;
  localparam int unsigned FLAG_SF   = 2;
  localparam int unsigned FLAG_GT   = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Request/response channel between a command initiator (master) and the ALU responder (slave).
interface alu_cmd_responder_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned TAG_W = 2
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] resp_tag;
  logic             gt_zero_flag;
  logic             SF;
  logic             CF;
  logic             ZF;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, result, resp_tag, gt_zero_flag, SF, CF, ZF, err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, result, resp_tag, gt_zero_flag, SF, CF, ZF, err, busy
  );

endinterface

// File: rtl/alu_resp_fifo.sv
// Synchronous response FIFO; dout shows the head entry and is forced to 0 when empty.
module alu_resp_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] dout
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array, no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (PtrW + 1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (PtrW + 1)'(1);
    end
  end

endmodule

// File: rtl/alu_cmd_responder.sv
// ALU command responder: accepts one op at a time, executes it and buffers the response.
// Optional feature macro: ALU_MULT_EN builds the iterative shift-add multiplier for op 111;
// without it op 111 completes on the EXEC path with err=1 and a zero result.
module alu_cmd_responder
  import alu_resp_pkg::*;
#(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned TAG_W      = 2,
  parameter int unsigned RESP_DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  alu_cmd_responder_if.slave bus
);

  localparam int unsigned EntryW = 1 + NUM_FLAGS + TAG_W + WIDTH;

  logic [1:0]           state_q, state_d;
  logic [2:0]           op_q;
  logic [WIDTH-1:0]     a_q, b_q, res_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 cf_q, err_q;
  logic                 accept, push, full, empty;
  logic [EntryW-1:0]    din, dout;
  logic [NUM_FLAGS-1:0] flags_in, flags_out;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cf, alu_err;
  logic [WIDTH:0]       sum, diff;

`ifdef ALU_MULT_EN
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] prod_q, prod_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CntW-1:0]    cnt_q;
  logic               mul_done;

  assign mul_done = (cnt_q == CntW'(WIDTH - 1));
  assign prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
`endif

  // req_ready is forced low while reset is held, not just after it.
  assign bus.req_ready = (state_q == StIdle) && !full && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = (state_q == StPush);
  assign bus.busy      = (state_q != StIdle);

  // Single-cycle ALU for every op except an enabled multiply.
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_cf = sum[WIDTH];  end
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_cf = diff[WIDTH]; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin alu_res = {a_q[WIDTH-2:0], 1'b0}; alu_cf = a_q[WIDTH-1]; end
      default: alu_err = 1'b1;  // multiply reaching EXEC means the multiplier is not built
    endcase
  end

  // FSM next state: IDLE -> EXEC|MUL -> PUSH -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef ALU_MULT_EN
          state_d = (bus.req_op == OP_MUL) ? StMul : StExec;
`else
          state_d = StExec;
`endif
        end
      end
      StExec: state_d = StPush;
`ifdef ALU_MULT_EN
      StMul:  if (mul_done) state_d = StPush;
`else
      StMul:  state_d = StIdle;
`endif
      StPush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state, latched command and the finished result waiting to be pushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= bus.req_op;
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        tag_q <= bus.req_tag;
      end
      if (state_q == StExec) begin
        res_q <= alu_res;
        cf_q  <= alu_cf;
        err_q <= alu_err;
      end
`ifdef ALU_MULT_EN
      else if (state_q == StMul && mul_done) begin
        res_q <= prod_d[WIDTH-1:0];
        cf_q  <= |prod_d[2*WIDTH-1:WIDTH];
        err_q <= 1'b0;
      end
`endif
    end
  end

`ifdef ALU_MULT_EN
  // Shift-add multiplier: one multiplier bit per MUL cycle, WIDTH cycles total.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept) begin
      prod_q   <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, bus.req_a};
      mplier_q <= bus.req_b;
      cnt_q    <= '0;
    end else if (state_q == StMul) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CntW'(1);
    end
  end
`endif

  // Flags are derived from the final result at push time.
  always_comb begin
    flags_in          = '0;
    flags_in[FLAG_ZF] = ~|res_q;
    flags_in[FLAG_CF] = cf_q;
    flags_in[FLAG_SF] = res_q[WIDTH-1];
    flags_in[FLAG_GT] = ~res_q[WIDTH-1] & (|res_q);
  end

  assign din = {err_q, flags_in, tag_q, res_q};

  alu_resp_fifo #(
    .DW    (EntryW),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (bus.resp_ready),
    .din   (din),
    .full  (full),
    .empty (empty),
    .dout  (dout)
  );

  assign {bus.err, flags_out, bus.resp_tag, bus.result} = dout;
  assign bus.resp_valid   = ~empty;
  assign bus.ZF           = flags_out[FLAG_ZF];
  assign bus.CF           = flags_out[FLAG_CF];
  assign bus.SF           = flags_out[FLAG_SF];
  assign bus.gt_zero_flag = flags_out[FLAG_GT];

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Self-checking bench for alu_cmd_responder: vector table, random ops against a
// reference model, backpressure ordering and reset during a multi-cycle op.
module tb_alu_cmd_responder;

  localparam int W = 6;
  localparam int M = 64;
`ifdef ALU_MULT_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_responder_if #(.WIDTH(W), .TAG_W(2)) bus ();

  alu_cmd_responder #(
    .WIDTH      (W),
    .TAG_W      (2),
    .RESP_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] op;
    int a, b, tag;
    int res;
    bit cf, zf, sf, gt, err;
    int lat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Present a request at a falling edge and hold it until accepted (bounded).
  // Returns at the falling edge just after the accepting rising edge.
  task automatic send(input logic [2:0] op, input int a, input int b, input int tag,
                      output bit ok);
    @(negedge clk);
    bus.req_op    = op;
    bus.req_a     = a[W-1:0];
    bus.req_b     = b[W-1:0];
    bus.req_tag   = tag[1:0];
    bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  // lat = index k of the edge N+k whose sampled resp_valid is first high.
  task automatic wait_resp(output int lat, output int res, output int tag, output int cf,
                           output int zf, output int sf, output int gt, output int err);
    lat = 0; res = -1; tag = -1; cf = -1; zf = -1; sf = -1; gt = -1; err = -1;
    for (int k = 1; k <= 40; k++) begin
      if (bus.resp_valid) begin
        lat = k;
        res = int'(bus.result); tag = int'(bus.resp_tag);
        cf = int'(bus.CF); zf = int'(bus.ZF); sf = int'(bus.SF);
        gt = int'(bus.gt_zero_flag); err = int'(bus.err);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input int a, input int b,
                       input int tag, input int eres, input bit ecf, input bit ezf,
                       input bit esf, input bit egt, input bit eerr, input int elat);
    bit ok;
    int lat, res, rtag, cf, zf, sf, gt, err;
    send(op, a, b, tag, ok);
    check({nm, " accepted"}, 32'(ok), 32'd1);
    wait_resp(lat, res, rtag, cf, zf, sf, gt, err);
    check({nm, " latency"}, lat, elat);
    check({nm, " result"}, res, eres);
    check({nm, " tag"}, rtag, tag);
    check({nm, " CF"}, cf, 32'(ecf));
    check({nm, " ZF"}, zf, 32'(ezf));
    check({nm, " SF"}, sf, 32'(esf));
    check({nm, " gt"}, gt, 32'(egt));
    check({nm, " err"}, err, 32'(eerr));
  endtask

  // Reference model from the arithmetic definitions, using plain integers.
  task automatic model(input int op, input int a, input int b, output int res, output bit cf,
                       output bit zf, output bit sf, output bit gt, output bit err);
    int p;
    cf = 1'b0; err = 1'b0; res = 0;
    case (op)
      0: begin p = a + b; res = p % M; cf = (p >= M); end
      1: begin res = (a - b + M) % M; cf = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = M - 1 - a;
      6: begin res = (a * 2) % M; cf = (a >= M / 2); end
      default: begin
        if (MulEn) begin p = a * b; res = p % M; cf = (p >= M); end
        else err = 1'b1;
      end
    endcase
    zf = (res == 0);
    sf = (res >= M / 2);
    gt = !sf && !zf;
  endtask

  initial begin
    bit ok, seen;
    int lat, res, rtag, cf, zf, sf, gt, err;
    int mres, mlat;
    bit mcf, mzf, msf, mgt, merr;

    tbl[0] = '{3'd0, 30, 40, 1, 6,  1, 0, 0, 1, 0, 3};
    tbl[1] = '{3'd1, 5,  5,  2, 0,  0, 1, 0, 0, 0, 3};
    tbl[2] = '{3'd1, 3,  5,  3, 62, 1, 0, 1, 0, 0, 3};
    tbl[3] = '{3'd2, 42, 15, 0, 10, 0, 0, 0, 1, 0, 3};
    tbl[4] = '{3'd3, 32, 1,  1, 33, 0, 0, 1, 0, 0, 3};
    tbl[5] = '{3'd4, 63, 63, 2, 0,  0, 1, 0, 0, 0, 3};
    tbl[6] = '{3'd5, 0,  17, 3, 63, 0, 0, 1, 0, 0, 3};
    tbl[7] = '{3'd6, 33, 0,  0, 2,  1, 0, 0, 1, 0, 3};
    if (MulEn) begin
      tbl[8] = '{3'd7, 7, 9, 1, 63, 0, 0, 1, 0, 0, 8};
      tbl[9] = '{3'd7, 8, 9, 2, 8,  1, 0, 0, 1, 0, 8};
    end else begin
      tbl[8] = '{3'd7, 7, 9, 1, 0, 0, 1, 0, 0, 1, 3};
      tbl[9] = '{3'd7, 8, 9, 2, 0, 0, 1, 0, 0, 1, 3};
    end

    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_tag = '0; bus.resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 0);
    check("rst resp_valid", 32'(bus.resp_valid), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst result", 32'(bus.result), 0);
    check("rst flags", 32'({bus.gt_zero_flag, bus.SF, bus.CF, bus.ZF, bus.err}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle req_ready", 32'(bus.req_ready), 1);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].res,
            tbl[i].cf, tbl[i].zf, tbl[i].sf, tbl[i].gt, tbl[i].err, tbl[i].lat);
    end

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      int op, a, b, t;
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, M - 1));
      b  = int'($urandom_range(0, M - 1));
      t  = int'($urandom_range(0, 3));
      model(op, a, b, mres, mcf, mzf, msf, mgt, merr);
      mlat = (op == 7 && MulEn) ? W + 2 : 3;
      do_op($sformatf("rnd%0d op%0d a%0d b%0d", i, op, a, b), op[2:0], a, b, t, mres,
            mcf, mzf, msf, mgt, merr, mlat);
    end

    // Backpressure: two fill the FIFO, third waits for a pop, order preserved
    bus.resp_ready = 1'b0;
    send(3'd0, 1, 2, 0, ok);
    check("bp accept0", 32'(ok), 1);
    send(3'd0, 3, 4, 1, ok);
    check("bp accept1", 32'(ok), 1);
    bus.req_op = 3'd0; bus.req_a = 6'd5; bus.req_b = 6'd6; bus.req_tag = 2'd2;
    bus.req_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready) seen = 1'b1;
      @(negedge clk);
    end
    check("bp ready held low", 32'(seen), 0);
    check("bp head valid", 32'(bus.resp_valid), 1);
    check("bp head tag0", 32'(bus.resp_tag), 0);
    check("bp head res0", 32'(bus.result), 3);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bp third accepted", 32'(ok), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.resp_ready = 1'b1;
    wait_resp(lat, res, rtag, cf, zf, sf, gt, err);
    check("bp tag1", rtag, 1);
    check("bp res1", res, 7);
    wait_resp(lat, res, rtag, cf, zf, sf, gt, err);
    check("bp tag2", rtag, 2);
    check("bp res2", res, 11);
    check("bp drained", 32'(bus.resp_valid), 0);

    // Reset during the third multiply cycle with one response buffered
    bus.resp_ready = 1'b0;
    send(3'd0, 2, 2, 3, ok);
    wait_resp(lat, res, rtag, cf, zf, sf, gt, err);
    check("mr buffered", 32'(bus.resp_valid), 1);
    send(3'd7, 7, 9, 1, ok);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mr resp_valid", 32'(bus.resp_valid), 0);
    check("mr result", 32'(bus.result), 0);
    check("mr resp_tag", 32'(bus.resp_tag), 0);
    check("mr flags", 32'({bus.gt_zero_flag, bus.SF, bus.CF, bus.ZF, bus.err}), 0);
    check("mr busy", 32'(bus.busy), 0);
    check("mr req_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("mr nothing emitted", 32'(seen), 0);
    bus.resp_ready = 1'b1;
    do_op("post-reset add", 3'd0, 1, 1, 0, 2, 0, 0, 0, 1, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

endmodule
